// File: rtl/pass_ram_writer.sv
// Password enrollment controller: buffers keypad digits for one user and, on the
// pound key, writes them plus a terminator word into the shared 64x8 password RAM.
module pass_ram_writer #(
    parameter int         MIN_DIGITS = 4,
    parameter int         MAX_DIGITS = 7,
    parameter logic [7:0] TERM_WORD  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pass_change,
    input  logic [2:0] address_user,
    input  logic [3:0] pass_input,
    input  logic       pass_load,
    input  logic       pass_pound,
    output logic [5:0] address_pass,
    output logic [7:0] data_pass,
    output logic       wren_pass,
    output logic       busy,
    output logic       done,
    output logic       pwd_error,
    output logic [2:0] digit_count
);

    localparam logic [2:0] MIN_C = 3'(MIN_DIGITS);
    localparam logic [2:0] MAX_C = 3'(MAX_DIGITS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_TERM    = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  user_r;
    logic [2:0]  user_s;
    logic [2:0]  count_r;
    logic [2:0]  count_s;
    logic [2:0]  cnt_upd_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_s;
    logic [3:0]  buf_r [0:7];
    logic        buf_we_s;
    logic        buf_clr_s;
    logic        ovf_s;

    logic        load_q_r;
    logic        pound_q_r;
    logic        load_evt_r;
    logic        pound_evt_r;
    logic [3:0]  digit_r;

    logic        wren_r;
    logic [5:0]  addr_r;
    logic [7:0]  data_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        wren_s;
    logic [5:0]  addr_s;
    logic [7:0]  data_s;

    // Edge detectors; the digit is captured together with its strobe edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q_r    <= 1'b0;
            pound_q_r   <= 1'b1;
            load_evt_r  <= 1'b0;
            pound_evt_r <= 1'b0;
            digit_r     <= 4'h0;
        end else begin
            load_q_r    <= pass_load;
            pound_q_r   <= pass_pound;
            load_evt_r  <= pass_load & ~load_q_r;
            pound_evt_r <= ~pass_pound & pound_q_r;
            digit_r     <= pass_input;
        end
    end

    // Next-state logic; a same-cycle digit is counted before the pound length check
    always_comb begin
        state_s   = state_r;
        user_s    = user_r;
        count_s   = count_r;
        idx_s     = idx_r;
        cnt_upd_s = count_r;
        buf_we_s  = 1'b0;
        buf_clr_s = 1'b0;
        ovf_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pass_change) begin
                    user_s  = address_user;
                    count_s = 3'd0;
                    state_s = ST_COLLECT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (!pass_change) begin
                    count_s   = 3'd0;
                    buf_clr_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    if (load_evt_r) begin
                        if (count_r < MAX_C) begin
                            buf_we_s  = 1'b1;
                            cnt_upd_s = count_r + 3'd1;
                        end else begin
                            ovf_s = 1'b1;
                        end
                    end else begin
                        ovf_s = 1'b0;
                    end
                    count_s = cnt_upd_s;
                    if (ovf_s) begin
                        state_s = ST_ERR;
                    end else if (pound_evt_r) begin
                        if (cnt_upd_s < MIN_C) begin
                            state_s = ST_ERR;
                        end else begin
                            idx_s   = 3'd0;
                            state_s = ST_WRITE;
                        end
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end
            end
            ST_WRITE: begin
                idx_s = idx_r + 3'd1;
                if (idx_r == count_r - 3'd1) begin
                    state_s = ST_TERM;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_TERM: begin
                state_s = ST_DONE;
            end
            ST_DONE, ST_ERR: begin
                if (!pass_change) begin
                    count_s = 3'd0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                count_s = 3'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // RAM port values for the state being entered, so the registered outputs line up with it
    always_comb begin
        wren_s = 1'b0;
        addr_s = 6'd0;
        data_s = 8'h00;
        case (state_s)
            ST_WRITE: begin
                wren_s = 1'b1;
                addr_s = {user_s, idx_s};
                if (buf_we_s && (idx_s == count_r)) begin
                    data_s = {4'h0, digit_r};
                end else begin
                    data_s = {4'h0, buf_r[idx_s]};
                end
            end
            ST_TERM: begin
                wren_s = 1'b1;
                addr_s = {user_s, count_s};
                data_s = TERM_WORD;
            end
            default: begin
                wren_s = 1'b0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            user_r  <= 3'd0;
            count_r <= 3'd0;
            idx_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            user_r  <= user_s;
            count_r <= count_s;
            idx_r   <= idx_s;
        end
    end

    // Digit buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                buf_r[i] <= 4'h0;
            end
        end else if (buf_clr_s) begin
            for (int i = 0; i < 8; i++) begin
                buf_r[i] <= 4'h0;
            end
        end else if (buf_we_s) begin
            buf_r[count_r] <= digit_r;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wren_r <= 1'b0;
            addr_r <= 6'd0;
            data_r <= 8'h00;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            wren_r <= wren_s;
            addr_r <= addr_s;
            data_r <= data_s;
            busy_r <= (state_s == ST_COLLECT) || (state_s == ST_WRITE) || (state_s == ST_TERM);
            done_r <= (state_s == ST_DONE);
            err_r  <= (state_s == ST_ERR);
        end
    end

    assign wren_pass    = wren_r;
    assign address_pass = addr_r;
    assign data_pass    = data_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign pwd_error    = err_r;
    assign digit_count  = count_r;

endmodule

// File: tb/tb_pass_ram_writer.sv
// Directed bench for pass_ram_writer: logs every RAM write and checks it against
// hand-computed address/data sequences and status flags.
module tb_pass_ram_writer;

    logic       clk;
    logic       rst;
    logic       pass_change;
    logic [2:0] address_user;
    logic [3:0] pass_input;
    logic       pass_load;
    logic       pass_pound;
    logic [5:0] address_pass;
    logic [7:0] data_pass;
    logic       wren_pass;
    logic       busy;
    logic       done;
    logic       pwd_error;
    logic [2:0] digit_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int zero_viol = 0;
    logic [13:0] wr_q[$];
    int          wr_cyc[$];
    logic [13:0] exp_q[$];

    pass_ram_writer dut (
        .clk          (clk),
        .rst          (rst),
        .pass_change  (pass_change),
        .address_user (address_user),
        .pass_input   (pass_input),
        .pass_load    (pass_load),
        .pass_pound   (pass_pound),
        .address_pass (address_pass),
        .data_pass    (data_pass),
        .wren_pass    (wren_pass),
        .busy         (busy),
        .done         (done),
        .pwd_error    (pwd_error),
        .digit_count  (digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write logger
    always @(negedge clk) begin
        if (wren_pass) begin
            wr_q.push_back({address_pass, data_pass});
            wr_cyc.push_back(cyc);
        end else if (address_pass != 6'd0 || data_pass != 8'h00) begin
            zero_viol <= zero_viol + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        pass_input = d;
        pass_load  = 1'b1;
        tick(2);
        pass_load  = 1'b0;
        tick(2);
    endtask

    task automatic pound();
        pass_pound = 1'b0;
        tick(2);
        pass_pound = 1'b1;
        tick(2);
    endtask

    task automatic clear_log();
        wr_q.delete();
        wr_cyc.delete();
        exp_q.delete();
    endtask

    task automatic expect_wr(input logic [5:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic chk_writes(input string tag);
        chk($sformatf("%s_nwr", tag), 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            chk($sformatf("%s_wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
        end
        if (wr_q.size() > 1) begin
            chk($sformatf("%s_consec", tag), 32'(wr_cyc[wr_q.size()-1] - wr_cyc[0]),
                32'(wr_q.size() - 1));
        end
    endtask

    initial begin
        rst = 1'b0; pass_change = 1'b0; address_user = 3'd0;
        pass_input = 4'h0; pass_load = 1'b0; pass_pound = 1'b1;

        // Reset
        tick(3);
        chk("rst_outs", {23'd0, wren_pass, busy, done, pwd_error, digit_count, 2'b00},
            32'd0);
        chk("rst_addr_data", {18'd0, address_pass, data_pass}, 32'd0);
        rst = 1'b1;
        tick(2);
        chk("idle_outs", {18'd0, wren_pass, busy, done, pwd_error, digit_count, address_pass[2:0]},
            32'd0);

        // Nominal enrollment, user 2
        clear_log();
        address_user = 3'd2; pass_change = 1'b1;
        tick(1);
        chk("nom_busy", 32'(busy), 32'd1);
        press(4'hC); press(4'hC); press(4'hC); press(4'h1);
        chk("nom_cnt_pre", 32'(digit_count), 32'd4);
        pound();
        tick(6);
        expect_wr(6'd16, 8'h0C); expect_wr(6'd17, 8'h0C); expect_wr(6'd18, 8'h0C);
        expect_wr(6'd19, 8'h01); expect_wr(6'd20, 8'hFF);
        chk_writes("nom");
        chk("nom_done", {29'd0, done, busy, pwd_error}, 32'b100);
        chk("nom_cnt", 32'(digit_count), 32'd4);
        pass_change = 1'b0;
        tick(2);
        chk("nom_release", {28'd0, done, digit_count}, 32'd0);

        // Short password
        clear_log();
        address_user = 3'd3; pass_change = 1'b1;
        tick(1);
        press(4'h1); press(4'h2); press(4'h3);
        pound();
        tick(2);
        chk("short_err", {30'd0, pwd_error, done}, 32'b10);
        chk("short_cnt", 32'(digit_count), 32'd3);
        chk_writes("short");
        pass_change = 1'b0;
        tick(2);
        chk("short_release", {30'd0, pwd_error, busy}, 32'd0);

        // Overflow, user 5
        clear_log();
        address_user = 3'd5; pass_change = 1'b1;
        tick(1);
        for (int i = 0; i < 7; i++) press(4'(i));
        chk("ovf_cnt7", {28'd0, pwd_error, digit_count}, 32'd7);
        press(4'h7);
        chk("ovf_err", 32'(pwd_error), 32'd1);
        chk_writes("ovf");
        pass_change = 1'b0;
        tick(2);

        // Maximum length, user 7
        clear_log();
        address_user = 3'd7; pass_change = 1'b1;
        tick(1);
        for (int i = 0; i < 7; i++) press(4'(9 - i));
        pound();
        tick(10);
        for (int i = 0; i < 7; i++) expect_wr(6'(56 + i), 8'(9 - i));
        expect_wr(6'd63, 8'hFF);
        chk_writes("max");
        chk("max_done", {30'd0, done, pwd_error}, 32'b10);
        pass_change = 1'b0;
        tick(2);

        // Abort after two digits
        clear_log();
        address_user = 3'd1; pass_change = 1'b1;
        tick(1);
        press(4'h4); press(4'h5);
        pass_change = 1'b0;
        tick(2);
        chk("abort_idle", {28'd0, busy, digit_count}, 32'd0);
        chk_writes("abort");

        // Held strobe counts once, then full enrollment, user 1
        clear_log();
        pass_change = 1'b1;
        tick(1);
        pass_input = 4'h6; pass_load = 1'b1;
        tick(5);
        pass_load = 1'b0;
        tick(2);
        chk("held_cnt", 32'(digit_count), 32'd1);
        press(4'h7); press(4'h8); press(4'h9);
        pound();
        tick(6);
        expect_wr(6'd8, 8'h06); expect_wr(6'd9, 8'h07); expect_wr(6'd10, 8'h08);
        expect_wr(6'd11, 8'h09); expect_wr(6'd12, 8'hFF);
        chk_writes("held");
        pass_change = 1'b0;
        tick(2);

        // Simultaneous load and pound with 3 prior digits, user 4
        clear_log();
        address_user = 3'd4; pass_change = 1'b1;
        tick(1);
        press(4'h1); press(4'h2); press(4'h3);
        pass_input = 4'h5; pass_load = 1'b1; pass_pound = 1'b0;
        tick(2);
        pass_load = 1'b0; pass_pound = 1'b1;
        tick(8);
        expect_wr(6'd32, 8'h01); expect_wr(6'd33, 8'h02); expect_wr(6'd34, 8'h03);
        expect_wr(6'd35, 8'h05); expect_wr(6'd36, 8'hFF);
        chk_writes("simul");
        chk("simul_done", {28'd0, done, digit_count}, 32'b1100);
        press(4'h3);
        chk("done_load_ignored", {28'd0, done, digit_count}, 32'b1100);
        pass_change = 1'b0;
        tick(2);

        // Reset mid-write, user 6
        clear_log();
        address_user = 3'd6; pass_change = 1'b1;
        tick(1);
        press(4'h2); press(4'h4); press(4'h6); press(4'h8);
        pass_pound = 1'b0;
        tick(3);
        #2 rst = 1'b0;
        #1;
        chk("midrst_outs", {26'd0, wren_pass, busy, done, digit_count}, 32'd0);
        pass_pound = 1'b1; pass_change = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        expect_wr(6'd48, 8'h02); expect_wr(6'd49, 8'h04);
        chk_writes("midrst");

        chk("idle_addr_data_zero", 32'(zero_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
